// File: rtl/ir_key_input_reg.sv
// Validated NEC key-code input register for the processor input port, with held-key repeat
// suppression. Define IR_ADDR_CHECK_EN to also require the frame custom code to match CUSTOM_CODE.
module ir_key_input_reg #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned HOLD_MS     = 120,
  parameter logic [15:0] CUSTOM_CODE = 16'h6B86
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iDATA_READY,
  input  logic [31:0] iDATA,
  input  logic        iRD,
  output logic [7:0]  oKEY,
  output logic        oVALID,
  output logic        oOVR,
  output logic [16:0] oDATA,
  output logic [7:0]  oERR_CNT
);

  localparam int unsigned HOLD_CYC = (CLK_HZ / 1000) * HOLD_MS;
  localparam int unsigned TimerW   = $clog2(HOLD_CYC + 1);
  localparam logic [TimerW-1:0] HoldReload = TimerW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {StIdle, StCheck, StHold} state_e;

  state_e              state_q;
  logic                ready_q;
  logic [31:0]         frame_q;
  logic                from_hold_q;
  logic [7:0]          last_key_q;
  logic [TimerW-1:0]   timer_q;
  logic [7:0]          key_q;
  logic                valid_q;
  logic                ovr_q;
  logic [7:0]          err_q;

  logic                rise;
  logic [7:0]          frame_key;
  logic                good;
  logic                timer_zero;

  assign rise       = iDATA_READY & ~ready_q;
  assign frame_key  = frame_q[23:16];
  assign timer_zero = (timer_q == '0);

`ifdef IR_ADDR_CHECK_EN
  assign good = (frame_q[31:24] == ~frame_q[23:16]) && (frame_q[15:0] == CUSTOM_CODE);
`else
  logic unused_code;
  assign unused_code = ^{CUSTOM_CODE, frame_q[15:0]};
  assign good = (frame_q[31:24] == ~frame_q[23:16]);
`endif

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      frame_q     <= '0;
      from_hold_q <= 1'b0;
      last_key_q  <= '0;
      timer_q     <= '0;
      key_q       <= '0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
      err_q       <= '0;
    end else begin
      ready_q <= iDATA_READY;
      // Read clears flags; an accept in the same cycle overrides below.
      if (iRD) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            frame_q     <= iDATA;
            from_hold_q <= 1'b0;
            state_q     <= StCheck;
          end
        end
        StHold: begin
          if (rise) begin
            frame_q     <= iDATA;
            from_hold_q <= 1'b1;
            state_q     <= StCheck;
            if (!timer_zero) timer_q <= timer_q - 1'b1;
          end else if (timer_zero) begin
            state_q    <= StIdle;
            last_key_q <= '0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        StCheck: begin
          if (good) begin
            if (!from_hold_q || (frame_key != last_key_q)) begin
              key_q      <= frame_key;
              last_key_q <= frame_key;
              valid_q    <= 1'b1;
              ovr_q      <= ~iRD & (ovr_q | valid_q);
            end
            timer_q <= HoldReload;
            state_q <= StHold;
          end else begin
            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
            state_q <= from_hold_q ? StHold : StIdle;
            if (!timer_zero) timer_q <= timer_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign oKEY     = key_q;
  assign oVALID   = valid_q;
  assign oOVR     = ovr_q;
  assign oERR_CNT = err_q;
  assign oDATA    = {7'b0, ovr_q, valid_q, key_q};

endmodule
